// File: rtl/bios_boot_loader_if.sv
// Bus between the boot loader and its surroundings: the request side
// (start/src_base/dst_base/length and status), the BIOS read port and the
// instruction-memory write port.
//
// Handshake: start is a one-cycle request pulse. It is accepted only when the
// loader is idle; a pulse seen while busy is dropped. src_base, dst_base and
// length are sampled on the accepting edge only. busy/done/err/cpu_hold are
// levels. mem_we is a one-cycle write strobe qualifying mem_addr/mem_data.
interface bios_boot_loader_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int SRC_ADDR_WIDTH = 10,
  parameter int DST_ADDR_WIDTH = 10
);
  logic                      start;
  logic [SRC_ADDR_WIDTH-1:0] src_base;
  logic [DST_ADDR_WIDTH-1:0] dst_base;
  logic [SRC_ADDR_WIDTH:0]   length;
  logic [SRC_ADDR_WIDTH-1:0] bios_addr;
  logic [DATA_WIDTH-1:0]     bios_q;
  logic [DST_ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]     mem_data;
  logic                      mem_we;
  logic                      busy;
  logic                      done;
  logic                      err;
  logic                      cpu_hold;

  // Host/BIOS side: issues requests, returns BIOS data, observes writes.
  modport master (
    output start, src_base, dst_base, length, bios_q,
    input  bios_addr, mem_addr, mem_data, mem_we, busy, done, err, cpu_hold
  );

  // Loader side.
  modport slave (
    input  start, src_base, dst_base, length, bios_q,
    output bios_addr, mem_addr, mem_data, mem_we, busy, done, err, cpu_hold
  );
endinterface

// File: rtl/bios_boot_loader.sv
// Boot sequencer: copies a block of BIOS words into instruction memory,
// one word per RD_LATENCY+1 cycles, holding the CPU until the copy finishes.
// Optionally launches a fixed copy on the first cycle after reset release.
module bios_boot_loader #(
  parameter int DATA_WIDTH     = 32,
  parameter int SRC_ADDR_WIDTH = 10,
  parameter int DST_ADDR_WIDTH = 10,
  parameter int RD_LATENCY     = 1,
  parameter int AUTO_BOOT      = 1,
  parameter int BOOT_SRC       = 0,
  parameter int BOOT_DST       = 0,
  parameter int BOOT_LEN       = 3
) (
  input  logic                clk,
  input  logic                reset,
  bios_boot_loader_if.slave   bus,
  output logic [2:0]          dbg_state
);

  localparam int LW = SRC_ADDR_WIDTH + 1;
  localparam int CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [LW-1:0] MAX_LEN  = LW'(1) << SRC_ADDR_WIDTH;
  localparam logic [CW-1:0] LAT_LAST = CW'(RD_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    READ   = 3'd2,
    WRITE  = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t                    state;
  logic                      boot_pending;
  logic [SRC_ADDR_WIDTH-1:0] src_r;
  logic [DST_ADDR_WIDTH-1:0] dst_r;
  logic [LW-1:0]             len_r;
  logic [LW-1:0]             idx;
  logic [CW-1:0]             lat_cnt;

  logic [SRC_ADDR_WIDTH-1:0] bios_addr_r;
  logic [DST_ADDR_WIDTH-1:0] mem_addr_r;
  logic [DATA_WIDTH-1:0]     mem_data_r;
  logic                      mem_we_r;
  logic                      busy_r;
  logic                      done_r;
  logic                      err_r;
  logic                      cpu_hold_r;

  logic                      req_go;
  logic [SRC_ADDR_WIDTH-1:0] req_src;
  logic [DST_ADDR_WIDTH-1:0] req_dst;
  logic [LW-1:0]             req_len;
  logic [LW-1:0]             idx_next;

  // Request selection: the pending auto-boot takes the place of a start pulse.
  always_comb begin
    req_go   = 1'b0;
    req_src  = bus.src_base;
    req_dst  = bus.dst_base;
    req_len  = bus.length;
    idx_next = idx + LW'(1);
    if (state == IDLE) begin
      if (boot_pending) begin
        req_go  = 1'b1;
        req_src = SRC_ADDR_WIDTH'(BOOT_SRC);
        req_dst = DST_ADDR_WIDTH'(BOOT_DST);
        req_len = LW'(BOOT_LEN);
      end else begin
        req_go = bus.start;
      end
    end
  end

  // Copy FSM with registered outputs; each output takes its new value on the
  // edge that enters the state it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      boot_pending <= (AUTO_BOOT != 0);
      src_r        <= '0;
      dst_r        <= '0;
      len_r        <= '0;
      idx          <= '0;
      lat_cnt      <= '0;
      bios_addr_r  <= '0;
      mem_addr_r   <= '0;
      mem_data_r   <= '0;
      mem_we_r     <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      cpu_hold_r   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          boot_pending <= 1'b0;
          cpu_hold_r   <= 1'b0;
          if (req_go) begin
            if (req_len > MAX_LEN) begin
              err_r  <= 1'b1;
              done_r <= 1'b1;
            end else if (req_len == '0) begin
              err_r  <= 1'b0;
              done_r <= 1'b1;
            end else begin
              err_r      <= 1'b0;
              done_r     <= 1'b0;
              busy_r     <= 1'b1;
              cpu_hold_r <= 1'b1;
              src_r      <= req_src;
              dst_r      <= req_dst;
              len_r      <= req_len;
              state      <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          bios_addr_r <= src_r;
          idx         <= '0;
          lat_cnt     <= '0;
          state       <= READ;
        end
        READ: begin
          if (lat_cnt == LAT_LAST) begin
            lat_cnt    <= '0;
            mem_data_r <= bus.bios_q;
            mem_addr_r <= dst_r + DST_ADDR_WIDTH'(idx);
            mem_we_r   <= 1'b1;
            state      <= WRITE;
          end else begin
            lat_cnt <= lat_cnt + CW'(1);
          end
        end
        WRITE: begin
          mem_we_r <= 1'b0;
          idx      <= idx_next;
          if (idx_next == len_r) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b1;
            cpu_hold_r <= 1'b0;
            state      <= FINISH;
          end else begin
            bios_addr_r <= src_r + SRC_ADDR_WIDTH'(idx_next);
            state       <= READ;
          end
        end
        FINISH: begin
          mem_we_r <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.bios_addr = bios_addr_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_data  = mem_data_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.err       = err_r;
  assign bus.cpu_hold  = cpu_hold_r;
  assign dbg_state     = state;

endmodule

// File: tb/tb_bios_boot_loader.sv
// Bench for bios_boot_loader. Instance A: auto-boot, read latency 1.
// Instance B: start-driven, read latency 2. BIOS contents are 0xA0A0_0000|addr
// for A and 0xB0B0_0000|addr for B. Writes are logged with cycle stamps and
// checked against hand-computed expectations by each test task.
module tb_bios_boot_loader;

  typedef struct {
    int          cyc;
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic [2:0] dbg_a, dbg_b;
  logic [9:0] addr_d = '0;
  int cyc = 0;
  int checks = 0;
  int fails = 0;
  int dbl_we_b = 0;
  logic prev_we_b = 1'b0;
  wr_t wr_a[$];
  wr_t wr_b[$];

  bios_boot_loader_if #(.DATA_WIDTH(32), .SRC_ADDR_WIDTH(10), .DST_ADDR_WIDTH(10)) bus_a ();
  bios_boot_loader_if #(.DATA_WIDTH(32), .SRC_ADDR_WIDTH(10), .DST_ADDR_WIDTH(10)) bus_b ();

  bios_boot_loader #(.RD_LATENCY(1), .AUTO_BOOT(1), .BOOT_SRC(0), .BOOT_DST(0), .BOOT_LEN(3))
    u_a (.clk(clk), .reset(rst_a), .bus(bus_a), .dbg_state(dbg_a));
  bios_boot_loader #(.RD_LATENCY(2), .AUTO_BOOT(0))
    u_b (.clk(clk), .reset(rst_b), .bus(bus_b), .dbg_state(dbg_b));

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // BIOS models: A combinational (latency 1), B one register stage (latency 2)
  always @(posedge clk) addr_d <= bus_b.bios_addr;
  assign bus_a.bios_q = 32'hA0A0_0000 | {22'd0, bus_a.bios_addr};
  assign bus_b.bios_q = 32'hB0B0_0000 | {22'd0, addr_d};

  // write loggers
  always @(negedge clk) begin
    if (bus_a.mem_we === 1'b1) wr_a.push_back('{cyc, bus_a.mem_addr, bus_a.mem_data});
    if (bus_b.mem_we === 1'b1) wr_b.push_back('{cyc, bus_b.mem_addr, bus_b.mem_data});
    if (bus_b.mem_we === 1'b1 && prev_we_b) dbl_we_b = dbl_we_b + 1;
    prev_we_b = (bus_b.mem_we === 1'b1);
  end

  // driver: one-cycle start pulse request on B (issued at a negedge)
  task automatic drive_start_b(input logic [9:0] src, input logic [9:0] dst, input logic [10:0] len);
    bus_b.start    = 1'b1;
    bus_b.src_base = src;
    bus_b.dst_base = dst;
    bus_b.length   = len;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (bus_b.bios_addr !== 10'd0) begin fails++; $display("FAIL rst_bios_addr: got %0h want 0", bus_b.bios_addr); end
    checks++; if (bus_b.mem_addr !== 10'd0) begin fails++; $display("FAIL rst_mem_addr: got %0h want 0", bus_b.mem_addr); end
    checks++; if (bus_b.mem_data !== 32'd0) begin fails++; $display("FAIL rst_mem_data: got %0h want 0", bus_b.mem_data); end
    checks++; if (bus_b.mem_we !== 1'b0) begin fails++; $display("FAIL rst_mem_we: got %b want 0", bus_b.mem_we); end
    checks++; if (bus_b.busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", bus_b.busy); end
    checks++; if (bus_b.done !== 1'b0) begin fails++; $display("FAIL rst_done: got %b want 0", bus_b.done); end
    checks++; if (bus_b.err !== 1'b0) begin fails++; $display("FAIL rst_err: got %b want 0", bus_b.err); end
    checks++; if (bus_b.cpu_hold !== 1'b1) begin fails++; $display("FAIL rst_cpu_hold: got %b want 1", bus_b.cpu_hold); end
    checks++; if (bus_a.cpu_hold !== 1'b1) begin fails++; $display("FAIL rst_cpu_hold_a: got %b want 1", bus_a.cpu_hold); end
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus_b.cpu_hold !== 1'b0) begin fails++; $display("FAIL idle_cpu_hold: got %b want 0", bus_b.cpu_hold); end
    checks++; if (bus_b.busy !== 1'b0) begin fails++; $display("FAIL idle_no_autoboot: busy %b want 0", bus_b.busy); end
  endtask

  task automatic test_auto_boot();
    int c0;
    wr_a.delete();
    rst_a = 1'b0;
    c0 = cyc;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 7) begin
        checks++; if (bus_a.busy !== 1'b1 || bus_a.done !== 1'b0 || bus_a.cpu_hold !== 1'b1) begin
          fails++; $display("FAIL boot_busy_k7: busy %b done %b hold %b want 1 0 1", bus_a.busy, bus_a.done, bus_a.cpu_hold); end
      end
      if (k == 8) begin
        checks++; if (bus_a.done !== 1'b1 || bus_a.cpu_hold !== 1'b0 || bus_a.busy !== 1'b0) begin
          fails++; $display("FAIL boot_done_k8: done %b hold %b busy %b want 1 0 0", bus_a.done, bus_a.cpu_hold, bus_a.busy); end
      end
    end
    checks++; if (wr_a.size() != 3) begin fails++; $display("FAIL boot_write_count: got %0d want 3", wr_a.size()); end
    for (int i = 0; i < 3 && i < wr_a.size(); i++) begin
      checks++; if (wr_a[i].addr !== 10'(i) || wr_a[i].data !== (32'hA0A0_0000 | 32'(i)) || wr_a[i].cyc != c0 + 3 + 2 * i) begin
        fails++; $display("FAIL boot_write_%0d: got addr %0h data %0h cyc %0d want %0h %0h %0d",
                          i, wr_a[i].addr, wr_a[i].data, wr_a[i].cyc - c0, i, 32'hA0A0_0000 | 32'(i), 3 + 2 * i); end
    end
    checks++; if (bus_a.err !== 1'b0) begin fails++; $display("FAIL boot_err: got %b want 0", bus_a.err); end
  endtask

  task automatic test_wrap();
    int c0;
    logic [31:0] exp_data[4];
    exp_data[0] = 32'hB0B0_03FE; exp_data[1] = 32'hB0B0_03FF;
    exp_data[2] = 32'hB0B0_0000; exp_data[3] = 32'hB0B0_0001;
    wr_b.delete();
    drive_start_b(10'd1022, 10'd5, 11'd4);
    c0 = cyc;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus_b.start = 1'b0; bus_b.src_base = 10'd300; bus_b.dst_base = 10'd77; bus_b.length = 11'd9;
      end
      if (k == 2) begin checks++; if (bus_b.bios_addr !== 10'd1022) begin fails++; $display("FAIL wrap_addr0: got %0d want 1022", bus_b.bios_addr); end end
      if (k == 5) begin checks++; if (bus_b.bios_addr !== 10'd1023) begin fails++; $display("FAIL wrap_addr1: got %0d want 1023", bus_b.bios_addr); end end
      if (k == 8) begin checks++; if (bus_b.bios_addr !== 10'd0) begin fails++; $display("FAIL wrap_addr2: got %0d want 0", bus_b.bios_addr); end end
      if (k == 11) begin checks++; if (bus_b.bios_addr !== 10'd1) begin fails++; $display("FAIL wrap_addr3: got %0d want 1", bus_b.bios_addr); end end
      if (k == 13) begin checks++; if (bus_b.busy !== 1'b1 || bus_b.done !== 1'b0) begin fails++; $display("FAIL wrap_busy_k13: busy %b done %b want 1 0", bus_b.busy, bus_b.done); end end
      if (k == 14) begin checks++; if (bus_b.busy !== 1'b0 || bus_b.done !== 1'b1 || bus_b.cpu_hold !== 1'b0) begin
        fails++; $display("FAIL wrap_done_k14: busy %b done %b hold %b want 0 1 0", bus_b.busy, bus_b.done, bus_b.cpu_hold); end end
    end
    checks++; if (wr_b.size() != 4) begin fails++; $display("FAIL wrap_write_count: got %0d want 4", wr_b.size()); end
    for (int i = 0; i < 4 && i < wr_b.size(); i++) begin
      checks++; if (wr_b[i].addr !== 10'(5 + i) || wr_b[i].data !== exp_data[i] || wr_b[i].cyc != c0 + 4 + 3 * i) begin
        fails++; $display("FAIL wrap_write_%0d: got addr %0d data %0h cyc %0d want %0d %0h %0d",
                          i, wr_b[i].addr, wr_b[i].data, wr_b[i].cyc - c0, 5 + i, exp_data[i], 4 + 3 * i); end
    end
  endtask

  task automatic test_max_len();
    drive_start_b(10'd0, 10'd0, 11'd1024);
    @(negedge clk);
    bus_b.start = 1'b0;
    checks++; if (bus_b.busy !== 1'b1 || bus_b.err !== 1'b0 || bus_b.done !== 1'b0 || bus_b.cpu_hold !== 1'b1) begin
      fails++; $display("FAIL max_len_accept: busy %b err %b done %b hold %b want 1 0 0 1", bus_b.busy, bus_b.err, bus_b.done, bus_b.cpu_hold); end
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero_len();
    wr_b.delete();
    drive_start_b(10'd3, 10'd3, 11'd0);
    @(negedge clk);
    bus_b.start = 1'b0;
    checks++; if (bus_b.done !== 1'b1 || bus_b.err !== 1'b0 || bus_b.busy !== 1'b0) begin
      fails++; $display("FAIL zero_len: done %b err %b busy %b want 1 0 0", bus_b.done, bus_b.err, bus_b.busy); end
    repeat (5) @(negedge clk);
    checks++; if (wr_b.size() != 0) begin fails++; $display("FAIL zero_len_writes: got %0d want 0", wr_b.size()); end
  endtask

  task automatic test_bad_len();
    wr_b.delete();
    drive_start_b(10'd3, 10'd3, 11'd1025);
    @(negedge clk);
    bus_b.start = 1'b0;
    checks++; if (bus_b.err !== 1'b1 || bus_b.done !== 1'b1 || bus_b.busy !== 1'b0) begin
      fails++; $display("FAIL bad_len: err %b done %b busy %b want 1 1 0", bus_b.err, bus_b.done, bus_b.busy); end
    repeat (5) @(negedge clk);
    checks++; if (wr_b.size() != 0) begin fails++; $display("FAIL bad_len_writes: got %0d want 0", wr_b.size()); end
  endtask

  task automatic test_reset_abort();
    int c0;
    wr_b.delete();
    drive_start_b(10'd10, 10'd20, 11'd3);
    c0 = cyc;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) bus_b.start = 1'b0;
    end
    checks++; if (bus_b.mem_we !== 1'b1 || bus_b.busy !== 1'b1) begin
      fails++; $display("FAIL abort_pre: mem_we %b busy %b want 1 1", bus_b.mem_we, bus_b.busy); end
    #2 rst_b = 1'b1;
    #1;
    checks++; if (bus_b.mem_we !== 1'b0 || bus_b.busy !== 1'b0 || bus_b.cpu_hold !== 1'b1) begin
      fails++; $display("FAIL abort_now: mem_we %b busy %b hold %b want 0 0 1", bus_b.mem_we, bus_b.busy, bus_b.cpu_hold); end
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    repeat (15) @(negedge clk);
    checks++; if (wr_b.size() != 2) begin fails++; $display("FAIL abort_write_count: got %0d want 2", wr_b.size()); end
    if (wr_b.size() >= 1) begin
      checks++; if (wr_b[0].addr !== 10'd20 || wr_b[0].data !== 32'hB0B0_000A || wr_b[0].cyc != c0 + 4) begin
        fails++; $display("FAIL abort_write0: got addr %0d data %0h cyc %0d want 20 b0b0000a 4", wr_b[0].addr, wr_b[0].data, wr_b[0].cyc - c0); end
    end
    checks++; if (bus_b.done !== 1'b0 || bus_b.busy !== 1'b0) begin
      fails++; $display("FAIL abort_after: done %b busy %b want 0 0", bus_b.done, bus_b.busy); end
  endtask

  task automatic test_back_to_back();
    int c0;
    wr_b.delete();
    drive_start_b(10'd100, 10'd200, 11'd3);
    c0 = cyc;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) bus_b.start = 1'b0;
      if (k == 3) drive_start_b(10'd500, 10'd0, 11'd5);
      if (k == 4) begin
        bus_b.start = 1'b0;
        checks++; if (bus_b.busy !== 1'b1 || bus_b.done !== 1'b0 || bus_b.err !== 1'b0) begin
          fails++; $display("FAIL busy_start_ignored: busy %b done %b err %b want 1 0 0", bus_b.busy, bus_b.done, bus_b.err); end
      end
      if (k == 11) begin checks++; if (bus_b.done !== 1'b1 || bus_b.busy !== 1'b0) begin
        fails++; $display("FAIL b2b_done_k11: done %b busy %b want 1 0", bus_b.done, bus_b.busy); end end
    end
    checks++; if (wr_b.size() != 3) begin fails++; $display("FAIL b2b_write_count: got %0d want 3", wr_b.size()); end
    for (int i = 0; i < 3 && i < wr_b.size(); i++) begin
      checks++; if (wr_b[i].addr !== 10'(200 + i) || wr_b[i].data !== (32'hB0B0_0064 + 32'(i)) || wr_b[i].cyc != c0 + 4 + 3 * i) begin
        fails++; $display("FAIL b2b_write_%0d: got addr %0d data %0h cyc %0d want %0d %0h %0d",
                          i, wr_b[i].addr, wr_b[i].data, wr_b[i].cyc - c0, 200 + i, 32'hB0B0_0064 + 32'(i), 4 + 3 * i); end
    end
    checks++; if (dbl_we_b != 0) begin fails++; $display("FAIL mem_we_consecutive: got %0d want 0", dbl_we_b); end
  endtask

  initial begin
    bus_a.start = 1'b0; bus_a.src_base = '0; bus_a.dst_base = '0; bus_a.length = '0;
    bus_b.start = 1'b0; bus_b.src_base = '0; bus_b.dst_base = '0; bus_b.length = '0;
    test_reset();
    test_auto_boot();
    test_wrap();
    test_max_len();
    test_zero_len();
    test_bad_len();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
